serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port: x  input  WIDTH  minuend; sampled on the accepted start cycle.
REQ-006 SHALL have port: y  input  WIDTH  subtrahend; sampled on the accepted start cycle.
REQ-007 SHALL have port: busy  output  1  high while a subtraction is in progress (RUN state).
REQ-008 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port: d  output  WIDTH  difference x - y modulo 2^WIDTH.
REQ-010 SHALL have port: bout  output  1  final borrow; 1 iff x < y unsigned.
REQ-011 SHALL have port: ovf  output  1  signed overflow flag; present only under SUB_OVERFLOW_EN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE + start=1: SHALL load x, y into internal shift registers, clear borrow flop and bit counter, go to RUN.
REQ-014 IDLE + start=0: SHALL remain in IDLE; outputs unchanged.
REQ-015 RUN: SHALL process one bit per cycle, LSB first: diff = xb ^ yb ^ b; b_next = (~xb & yb) | (~(xb ^ yb) & b).
REQ-016 RUN: SHALL shift each diff bit into an internal result shift register from the MSB end.
REQ-017 RUN: SHALL increment counter each cycle; after the WIDTH-th bit SHALL go to DONE.
REQ-018 DONE entry: SHALL copy internal result to d and final borrow to bout in the same edge.
REQ-019 DONE: done=1 for exactly one cycle, then SHALL return to IDLE unconditionally.
REQ-020 busy SHALL be 1 exactly in RUN (WIDTH cycles per operation).
REQ-021 Latency: start accepted at edge t -> done high during cycle after edge t+WIDTH+... precisely done=1 in the cycle following edge t+WIDTH, i.e. WIDTH+1 cycles after start sampled.
REQ-022 d, bout (and ovf) SHALL hold the last result until the next DONE; they SHALL NOT change during RUN.
REQ-023 start asserted in RUN or DONE SHALL be ignored (no queueing); x/y changes after acceptance SHALL have no effect.
REQ-024 Back-to-back: start high in the IDLE cycle following DONE SHALL be accepted; minimum issue interval WIDTH+2 cycles.
REQ-025 Counter width SHALL be sufficient for WIDTH (clog2(WIDTH)+1 bits); no wrap within an operation.

Reset
REQ-026 rst=1 SHALL force IDLE, clear shift registers, counter, borrow flop; busy=0, done=0, d=0, bout=0, ovf=0.
REQ-027 rst asserted in RUN or DONE SHALL abort the operation; no done pulse and no result update follows.
REQ-028 rst SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro SUB_OVERFLOW_EN defined: SHALL provide ovf, registered at DONE entry as (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]) on the captured operands.
REQ-030 Macro SUB_OVERFLOW_EN undefined: ovf port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-031 x=200, y=55, start 1 cycle -> busy 8 cycles, done pulse 9 cycles after start, d=145, bout=0.
REQ-032 x=5, y=7 -> d=254 (0xFE), bout=1; x=0, y=0 -> d=0, bout=0.
REQ-033 start at cycle 0 (x=9,y=4), start again at cycle 3 (x=1,y=1) -> only one done, d=5.
REQ-034 rst pulse during RUN cycle 4 -> busy=0, d=0 next cycle, no done pulse; new start afterwards gives correct result.
REQ-035 SUB_OVERFLOW_EN: x=0x80, y=0x01 -> d=0x7F, bout=0, ovf=1; x=0x10, y=0x01 -> ovf=0.
REQ-036 Exhaustive 256x256 sweep vs. reference model: d, bout (and ovf) match for every pair, back-to-back starts.

Source files
------------

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. On an accepted start the operands are loaded
// into shift registers and one difference bit is produced per clock, LSB
// first, using a full-subtractor cell with a single borrow flop. After WIDTH
// bits the assembled difference and the final borrow are published on d/bout
// and a one-cycle done pulse is raised.
//
// Configuration macro:
//   SUB_OVERFLOW_EN  when defined, adds the ovf output (signed overflow of the
//                    subtraction, evaluated on the captured operands).
//
// Ports:
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a subtraction (honoured only in IDLE)
//   x      in   minuend, captured on the accepted start cycle
//   y      in   subtrahend, captured on the accepted start cycle
//   busy   out  high while bits are being processed (RUN)
//   done   out  one-cycle pulse, result valid
//   d      out  x - y modulo 2^WIDTH, held until the next done
//   bout   out  final borrow, 1 iff x < y (unsigned)
//   ovf    out  signed overflow flag (SUB_OVERFLOW_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  // One extra bit over clog2 so the count never wraps inside an operation.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_sr;
  logic [WIDTH-1:0] y_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

`ifdef SUB_OVERFLOW_EN
  // Operand sign bits are shifted out of x_sr/y_sr, so keep copies for ovf.
  logic x_msb;
  logic y_msb;
`endif

  // Full-subtractor cell on the current LSBs.
  logic             xb;
  logic             yb;
  logic             diff_bit;
  logic             borrow_next;
  logic [WIDTH-1:0] res_next;

  assign xb          = x_sr[0];
  assign yb          = y_sr[0];
  assign diff_bit    = xb ^ yb ^ borrow;
  assign borrow_next = (~xb & yb) | (~(xb ^ yb) & borrow);
  // Difference bits enter at the MSB end so that after WIDTH shifts bit 0 of
  // the result sits at res_sr[0].
  assign res_next    = {diff_bit, res_sr[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are plain flops here (not a RAM), so
      // clearing them in reset costs nothing and keeps state deterministic.
      state  <= IDLE;
      x_sr   <= '0;
      y_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      x_msb  <= 1'b0;
      y_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            x_sr   <= x;
            y_sr   <= y;
            res_sr <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SUB_OVERFLOW_EN
            x_msb  <= x[WIDTH-1];
            y_msb  <= y[WIDTH-1];
`endif
          end
        end

        RUN: begin
          x_sr   <= x_sr >> 1;
          y_sr   <= y_sr >> 1;
          res_sr <= res_next;
          borrow <= borrow_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Publish on the same edge that consumes the last bit, so use the
            // next-state values rather than the registers.
            d     <= res_next;
            bout  <= borrow_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SUB_OVERFLOW_EN
            // diff_bit is the result MSB on this final step.
            ovf   <= (x_msb != y_msb) && (diff_bit != x_msb);
`endif
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed and randomized checks of serial_subtractor (WIDTH=8) against an
// arithmetic reference model. Define SUB_OVERFLOW_EN for both files to also
// check the ovf output.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] dm, output logic bm,
                                output logic om);
    int ia, ib, sa, sb, sd;
    ia = int'(a);
    ib = int'(b);
    dm = W'(ia - ib + (1 << W));
    bm = (ia < ib);
    sa = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
    sb = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
    sd = sa - sb;
    om = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
  endfunction

  // Issue one operation from IDLE and check timing, hold and result.
  // Returns in the IDLE cycle right after the done pulse.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] de;
    logic         be;
    logic         oe;
    logic [W-1:0] d_hold;
    logic         held;
    int           cycles;
    int           busy_cnt;
    model(a, b, de, be, oe);
    start = 1'b1;
    x     = a;
    y     = b;
    step();
    // Operand changes after acceptance must not matter.
    start    = 1'b0;
    x        = W'($urandom);
    y        = W'($urandom);
    d_hold   = d;
    held     = 1'b1;
    cycles   = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 4 * W) begin
      step();
      cycles++;
      if (!done) begin
        if (busy) busy_cnt++;
        if (d !== d_hold) held = 1'b0;
      end
    end
    check("latency", 32'(cycles), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("d_held_in_run", 32'(held), 32'd1);
    check("d", 32'(d), 32'(de));
    check("bout", 32'(bout), 32'(be));
`ifdef SUB_OVERFLOW_EN
    check("ovf", 32'(ovf), 32'(oe));
`endif
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int dones;
    logic [W-1:0] d_at_done;

    // Reset with start asserted: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    x     = 8'hFF;
    y     = 8'h01;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst   = 1'b0;
    start = 1'b0;
    step();
    step();
    check("idle_no_start_busy", 32'(busy), 32'd0);
    check("idle_no_start_done", 32'(done), 32'd0);

    // Directed values and boundaries.
    run_op(8'd200, 8'd55);
    check("d_200_55", 32'(d), 32'd145);
    run_op(8'd5, 8'd7);
    check("d_5_7", 32'(d), 32'hFE);
    check("bout_5_7", 32'(bout), 32'd1);
    run_op(8'd0, 8'd0);
    run_op(8'd0, 8'd255);
    run_op(8'd255, 8'd0);
    run_op(8'd255, 8'd255);
    run_op(8'h80, 8'h01);
`ifdef SUB_OVERFLOW_EN
    check("ovf_80_01", 32'(ovf), 32'd1);
`endif
    run_op(8'h10, 8'h01);
`ifdef SUB_OVERFLOW_EN
    check("ovf_10_01", 32'(ovf), 32'd0);
`endif
    run_op(8'h7F, 8'hFF);

    // Second start while running is ignored.
    start = 1'b1;
    x     = 8'd9;
    y     = 8'd4;
    step();
    start = 1'b0;
    x     = 8'd77;
    y     = 8'd3;
    step();
    step();
    start = 1'b1;
    x     = 8'd1;
    y     = 8'd1;
    step();
    start     = 1'b0;
    dones     = 0;
    d_at_done = '0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin
        dones++;
        d_at_done = d;
      end
      step();
    end
    check("ignored_start_dones", 32'(dones), 32'd1);
    check("ignored_start_d", 32'(d_at_done), 32'd5);

    // Reset in the middle of RUN aborts the operation.
    start = 1'b1;
    x     = 8'd100;
    y     = 8'd30;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    dones = 0;
    for (int i = 0; i < 2 * W; i++) begin
      step();
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    run_op(8'd100, 8'd30);

    // Randomized back-to-back operations.
    for (int i = 0; i < 500; i++) begin
      run_op(W'($urandom), W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
